// File: rtl/rw_multiq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rw_multiq: multi-channel read/write reordering queue, round-robin issue.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rw_multiq #(
    parameter int NCH      = 2,
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 4,
    parameter int LOGDEPTH = 2,
    parameter int LOGNCH   = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NCH-1:0]         validin,
    input  logic [NCH-1:0]         readin,
    input  logic [NCH*WIDTH-1:0]   inaddr,
    output logic [NCH-1:0]         accept,
    output logic [NCH-1:0]         bus_req,
    output logic [NCH-1:0]         match,
    output logic                   validout,
    output logic                   outisread,
    output logic [WIDTH-1:0]       outaddr,
    output logic [LOGNCH-1:0]      outch
);

    logic [NCH-1:0]    w_selrd;
    logic [WIDTH-1:0]  w_rdata [NCH];
    logic [WIDTH-1:0]  w_wdata [NCH];
    logic              w_grant;
    logic [LOGNCH-1:0] w_winner;
    logic [LOGNCH-1:0] w_idx;
    logic [LOGNCH-1:0] r_rr_ptr;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [WIDTH-1:0]    r_rmem [DEPTH];
        logic [WIDTH-1:0]    r_wmem [DEPTH];
        logic [LOGDEPTH-1:0] r_rhead;
        logic [LOGDEPTH-1:0] r_rtail;
        logic [LOGDEPTH-1:0] r_whead;
        logic [LOGDEPTH-1:0] r_wtail;
        logic [LOGDEPTH:0]   r_rcnt;
        logic [LOGDEPTH:0]   r_wcnt;
        logic                w_rempty;
        logic                w_rfull;
        logic                w_wempty;
        logic                w_wfull;
        logic                w_enq_r;
        logic                w_enq_w;
        logic                w_deq_r;
        logic                w_deq_w;
        logic                w_hit;
        logic [WIDTH-1:0]    w_addr;

        assign w_addr   = inaddr[c*WIDTH +: WIDTH];
        assign w_rempty = (r_rcnt == '0);
        assign w_wempty = (r_wcnt == '0);
        assign w_rfull  = (r_rcnt == (LOGDEPTH+1)'(DEPTH));
        assign w_wfull  = (r_wcnt == (LOGDEPTH+1)'(DEPTH));

        // Fullness alone gates accept, so a dequeue on the same edge never frees a slot early.
        assign accept[c] = validin[c] && !reset && !(readin[c] ? w_rfull : w_wfull);
        assign w_enq_r   = accept[c] && readin[c];
        assign w_enq_w   = accept[c] && !readin[c];

        // Compare the head read against every occupied write slot, oldest first.
        always_comb begin
            w_hit = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (((LOGDEPTH+1)'(k) < r_wcnt) &&
                    (r_wmem[r_whead + LOGDEPTH'(k)] == r_rmem[r_rhead])) begin
                    w_hit = 1'b1;
                end
            end
        end

        assign match[c]   = !w_rempty && w_hit;
        assign w_selrd[c] = !w_rempty && !w_hit;
        assign bus_req[c] = !w_rempty || !w_wempty;
        assign w_rdata[c] = r_rmem[r_rhead];
        assign w_wdata[c] = r_wmem[r_whead];
        assign w_deq_r    = w_grant && (w_winner == LOGNCH'(c)) && w_selrd[c];
        assign w_deq_w    = w_grant && (w_winner == LOGNCH'(c)) && !w_selrd[c];

        always_ff @(posedge clock) begin
            if (w_enq_r) begin
                r_rmem[r_rtail] <= w_addr;
            end
            if (w_enq_w) begin
                r_wmem[r_wtail] <= w_addr;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                r_rhead <= '0;
                r_rtail <= '0;
                r_whead <= '0;
                r_wtail <= '0;
                r_rcnt  <= '0;
                r_wcnt  <= '0;
            end else begin
                if (w_enq_r) begin
                    r_rtail <= r_rtail + LOGDEPTH'(1);
                end
                if (w_deq_r) begin
                    r_rhead <= r_rhead + LOGDEPTH'(1);
                end
                if (w_enq_w) begin
                    r_wtail <= r_wtail + LOGDEPTH'(1);
                end
                if (w_deq_w) begin
                    r_whead <= r_whead + LOGDEPTH'(1);
                end
                if (w_enq_r && !w_deq_r) begin
                    r_rcnt <= r_rcnt + (LOGDEPTH+1)'(1);
                end else if (!w_enq_r && w_deq_r) begin
                    r_rcnt <= r_rcnt - (LOGDEPTH+1)'(1);
                end
                if (w_enq_w && !w_deq_w) begin
                    r_wcnt <= r_wcnt + (LOGDEPTH+1)'(1);
                end else if (!w_enq_w && w_deq_w) begin
                    r_wcnt <= r_wcnt - (LOGDEPTH+1)'(1);
                end
            end
        end
    end

    // Round-robin: first requester strictly after the last winner, with wrap.
    always_comb begin
        w_grant  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= NCH; i++) begin
            w_idx = LOGNCH'((int'(r_rr_ptr) + i) % NCH);
            if (!w_grant && bus_req[w_idx]) begin
                w_grant  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr  <= LOGNCH'(NCH - 1);
            validout  <= 1'b0;
            outisread <= 1'b0;
            outaddr   <= '0;
            outch     <= '0;
        end else if (w_grant) begin
            r_rr_ptr  <= w_winner;
            validout  <= 1'b1;
            outisread <= w_selrd[w_winner];
            outaddr   <= w_selrd[w_winner] ? w_rdata[w_winner] : w_wdata[w_winner];
            outch     <= w_winner;
        end else begin
            validout  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rw_multiq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rw_multiq: randomized + directed scoreboard bench for rw_multiq.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_rw_multiq;

    localparam int NCH      = 4;
    localparam int W        = 2;
    localparam int DEPTH    = 4;
    localparam int LOGDEPTH = 2;
    localparam int LOGNCH   = 2;

    typedef logic [W-1:0] addr_t;
    typedef struct packed {
        logic              rd;
        logic [W-1:0]      addr;
        logic [LOGNCH-1:0] ch;
    } exp_t;

    logic                 clock;
    logic                 reset;
    logic [NCH-1:0]       validin;
    logic [NCH-1:0]       readin;
    logic [NCH*W-1:0]     inaddr;
    logic [NCH-1:0]       accept;
    logic [NCH-1:0]       bus_req;
    logic [NCH-1:0]       match;
    logic                 validout;
    logic                 outisread;
    logic [W-1:0]         outaddr;
    logic [LOGNCH-1:0]    outch;

    rw_multiq #(
        .NCH(NCH), .WIDTH(W), .DEPTH(DEPTH), .LOGDEPTH(LOGDEPTH), .LOGNCH(LOGNCH)
    ) dut (
        .clock(clock), .reset(reset), .validin(validin), .readin(readin),
        .inaddr(inaddr), .accept(accept), .bus_req(bus_req), .match(match),
        .validout(validout), .outisread(outisread), .outaddr(outaddr), .outch(outch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: plain per-channel queues and a last-winner index.
    addr_t rq [NCH][$];
    addr_t wq [NCH][$];
    int    rr = NCH - 1;
    exp_t  exp_q [$];

    int checks = 0;
    int errors = 0;

    logic [NCH-1:0]   drv_v, drv_r;
    logic [NCH*W-1:0] drv_a;

    bit    started  = 1'b0;
    bit    rst_edge = 1'b0;
    logic              l_rd;
    logic [W-1:0]      l_addr;
    logic [LOGNCH-1:0] l_ch;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_wq(input int c, input addr_t a);
        for (int i = 0; i < wq[c].size(); i++) begin
            if (wq[c][i] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit hazard(input int c);
        return (rq[c].size() > 0) && in_wq(c, rq[c][0]);
    endfunction

    task automatic clr();
        drv_v = '0;
        drv_r = '0;
        drv_a = '0;
    endtask

    task automatic put(input int c, input bit rd, input int a);
        drv_v[c]       = 1'b1;
        drv_r[c]       = rd;
        drv_a[c*W +: W] = W'(a);
    endtask

    // One clock: drive, compare combinational outputs, advance the model across the edge.
    task automatic step(input bit rst);
        bit   acc [NCH];
        int   win;
        exp_t e;
        @(negedge clock);
        validin = drv_v;
        readin  = drv_r;
        inaddr  = drv_a;
        reset   = rst;
        #1;
        for (int c = 0; c < NCH; c++) begin
            acc[c] = !rst && drv_v[c] &&
                     (drv_r[c] ? (rq[c].size() < DEPTH) : (wq[c].size() < DEPTH));
            chk($sformatf("accept[%0d]", c), int'(accept[c]), int'(acc[c]));
            chk($sformatf("bus_req[%0d]", c), int'(bus_req[c]),
                int'((rq[c].size() > 0) || (wq[c].size() > 0)));
            chk($sformatf("match[%0d]", c), int'(match[c]), int'(hazard(c)));
        end
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                rq[c].delete();
                wq[c].delete();
            end
            rr = NCH - 1;
        end else begin
            win = -1;
            for (int i = 1; i <= NCH; i++) begin
                int c;
                c = (rr + i) % NCH;
                if (win < 0 && (rq[c].size() > 0 || wq[c].size() > 0)) win = c;
            end
            if (win >= 0) begin
                e.ch = LOGNCH'(win);
                e.rd = (rq[win].size() > 0) && !hazard(win);
                if (e.rd) e.addr = rq[win].pop_front();
                else      e.addr = wq[win].pop_front();
                exp_q.push_back(e);
                rr = win;
            end
            for (int c = 0; c < NCH; c++) begin
                if (acc[c]) begin
                    if (drv_r[c]) rq[c].push_back(drv_a[c*W +: W]);
                    else          wq[c].push_back(drv_a[c*W +: W]);
                end
            end
        end
    endtask

    function automatic bit model_empty();
        for (int c = 0; c < NCH; c++) begin
            if (rq[c].size() > 0 || wq[c].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        clr();
        while (!model_empty() && n < 200) begin
            step(1'b0);
            n++;
        end
        chk("drain_timeout", int'(model_empty()), 1);
        step(1'b0);
        step(1'b0);
    endtask

    task automatic hazard_seq(input int ra);
        clr(); put(1, 0, 0); put(2, 0, 1); put(3, 0, 2); step(1'b0);
        clr(); put(0, 0, 1); put(1, 0, 3); put(2, 0, 3); put(3, 0, 3); step(1'b0);
        clr(); put(0, 0, 3); step(1'b0);
        clr(); put(0, 1, ra); step(1'b0);
        drain();
    endtask

    always @(posedge clock) begin
        rst_edge = reset;
        if (reset) started = 1'b1;
    end

    // Monitor: pops one expectation per issued request; otherwise checks hold/clear behaviour.
    always @(negedge clock) begin
        exp_t e;
        if (started) begin
            if (rst_edge) begin
                checks++;
                if (validout !== 1'b0 || outisread !== 1'b0 || outaddr !== '0 || outch !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs: got v=%b r=%b a=%0d ch=%0d expected all 0",
                             validout, outisread, outaddr, outch);
                end
                l_rd = 1'b0; l_addr = '0; l_ch = '0;
            end else if (validout === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue: got ch=%0d r=%b a=%0d expected none",
                             outch, outisread, outaddr);
                end else begin
                    e = exp_q.pop_front();
                    if (outisread !== e.rd || outaddr !== e.addr || outch !== e.ch) begin
                        errors++;
                        $display("FAIL issue: got ch=%0d r=%b a=%0d expected ch=%0d r=%b a=%0d",
                                 outch, outisread, outaddr, e.ch, e.rd, e.addr);
                    end
                    l_rd = e.rd; l_addr = e.addr; l_ch = e.ch;
                end
            end else begin
                checks++;
                if (validout !== 1'b0 || outisread !== l_rd || outaddr !== l_addr || outch !== l_ch) begin
                    errors++;
                    $display("FAIL idle_hold: got v=%b r=%b a=%0d ch=%0d expected v=0 r=%b a=%0d ch=%0d",
                             validout, outisread, outaddr, outch, l_rd, l_addr, l_ch);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        validin = '0;
        readin  = '0;
        inaddr  = '0;
        clr();
        step(1'b1);

        // Single-channel read latency
        clr(); put(0, 1, 2); step(1'b0);
        clr(); repeat (3) step(1'b0);

        // Read bypass vs. address hazard
        hazard_seq(3);
        hazard_seq(2);

        // Full read FIFO on ch1 under contention, write path still open, then wrap
        step(1'b1);
        for (int i = 0; i < 10; i++) begin
            clr();
            put(0, 1, i % 4); put(1, 1, (i + 1) % 4); put(2, 1, 3); put(3, 0, i % 4);
            step(1'b0);
        end
        clr(); put(1, 0, 2); put(0, 1, 1); step(1'b0);
        drain();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            clr(); put(1, 1, i % 4); step(1'b0);
        end
        drain();

        // Round-robin fairness from reset
        step(1'b1);
        for (int i = 0; i < 3; i++) begin
            clr();
            for (int c = 0; c < NCH; c++) put(c, 1, c);
            step(1'b0);
        end
        drain();

        // Mid-operation reset with entries queued
        for (int i = 0; i < 3; i++) begin
            clr(); put(0, 1, i); put(1, 0, i); put(2, 1, 1); step(1'b0);
        end
        clr(); step(1'b1);
        repeat (4) step(1'b0);

        // Randomized traffic with occasional reset
        for (int n = 0; n < 1500; n++) begin
            clr();
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) != 0) put(c, bit'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
            step($urandom_range(0, 299) == 0);
        end
        drain();

        @(negedge clock);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
